// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared screen/physics constants and state encoding
package flappy_pkg;

  // Screen geometry
  localparam int Y_START  = 232;
  localparam int Y_TOP    = 0;
  localparam int Y_BOTTOM = 479;
  localparam int BOX_H    = 16;
  localparam int Y_MAX    = Y_BOTTOM - BOX_H + 1;

  // Physics, in rows per frame tick
  localparam int GRAVITY  = 1;
  localparam int FLAP_VEL = -8;
  localparam int VMAX     = 10;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    ACTIVE = 2'b01,
    DEAD   = 2'b10
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered copy of a level plus rising-edge pulse
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember last cycle's level so a new press can be told from a held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/box_physics.sv
// rtl/box_physics.sv - per-frame gravity/flap integrator for the player box
module box_physics
  import flappy_pkg::*;
(
  input  logic              clk,
  input  logic              hard_reset_n,
  input  logic              refr_tick,
  input  logic              game_en,
  input  logic              game_reset,
  input  logic              up,
  output logic [9:0]        box_y,
  output logic signed [7:0] box_vel,
  output logic              bound_hit,
  output logic              active
);

  localparam logic signed [7:0]  VEL_FLAP = 8'(FLAP_VEL);
  localparam logic signed [7:0]  VEL_MAX  = 8'(VMAX);
  localparam logic signed [7:0]  VEL_G    = 8'(GRAVITY);
  localparam logic signed [11:0] Y_TOP_S  = 12'(Y_TOP);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);

  state_t              state, state_next;
  logic                up_rise;
  logic                flap_pend;
  logic                flap;
  logic                do_update;
  logic                floor_hit;
  logic                ceil_hit;
  logic signed [7:0]   v_inc, v_new;
  logic signed [11:0]  y_new;

  rise_detect u_up_rise (
    .clk   (clk),
    .rst_n (hard_reset_n),
    .din   (up),
    .rise  (up_rise)
  );

  // Candidate motion step; 12-bit signed so a flap near the ceiling goes negative instead of wrapping
  always_comb begin
    flap      = flap_pend | up_rise;
    v_inc     = box_vel + VEL_G;
    v_new     = flap ? VEL_FLAP : ((v_inc > VEL_MAX) ? VEL_MAX : v_inc);
    y_new     = $signed({2'b00, box_y}) + {{4{v_new[7]}}, v_new};
    ceil_hit  = (y_new < Y_TOP_S);
    floor_hit = (y_new >= Y_MAX_S);
    do_update = (state == ACTIVE) && game_en && refr_tick && !game_reset;
  end

  // State register
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) state <= HOLD;
    else               state <= state_next;
  end

  // Next state: restart wins, losing game_en beats a same-cycle tick
  always_comb begin
    state_next = state;
    if (game_reset) begin
      state_next = HOLD;
    end else begin
      case (state)
        HOLD:    if (game_en) state_next = ACTIVE;
        ACTIVE: begin
          if (!game_en)                    state_next = DEAD;
          else if (refr_tick && floor_hit) state_next = DEAD;
        end
        DEAD:    state_next = DEAD;
        default: state_next = HOLD;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    active = (state == ACTIVE);
  end

  // Position, velocity, landing flag and pending-flap latch
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      box_y     <= 10'(Y_START);
      box_vel   <= '0;
      bound_hit <= 1'b0;
      flap_pend <= 1'b0;
    end else if (game_reset) begin
      box_y     <= 10'(Y_START);
      box_vel   <= '0;
      bound_hit <= 1'b0;
      flap_pend <= 1'b0;
    end else begin
      if (refr_tick)                        flap_pend <= 1'b0;
      else if ((state == ACTIVE) && up_rise) flap_pend <= 1'b1;

      if (do_update) begin
        if (ceil_hit) begin
          box_y   <= 10'(Y_TOP);
          box_vel <= '0;
        end else if (floor_hit) begin
          box_y     <= 10'(Y_MAX);
          box_vel   <= '0;
          bound_hit <= 1'b1;
        end else begin
          box_y   <= y_new[9:0];
          box_vel <= v_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_box_physics.sv
// tb/tb_box_physics.sv - directed scoreboard bench for box_physics
module tb_box_physics;

  logic              clk;
  logic              hard_reset_n;
  logic              refr_tick;
  logic              game_en;
  logic              game_reset;
  logic              up;
  logic [9:0]        box_y;
  logic signed [7:0] box_vel;
  logic              bound_hit;
  logic              active;

  box_physics dut (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .refr_tick    (refr_tick),
    .game_en      (game_en),
    .game_reset   (game_reset),
    .up           (up),
    .box_y        (box_y),
    .box_vel      (box_vel),
    .bound_hit    (bound_hit),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int v;
    int hit;
    int act;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (0=hold, 1=active, 2=dead)
  int   m_y, m_v, m_hit, m_st;
  bit   m_pend, m_upreg;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_y = 232; m_v = 0; m_hit = 0; m_st = 0; m_pend = 0; m_upreg = 0;
  endtask

  task automatic cycle(input bit t, input bit u, input bit e, input bit g);
    exp_t ex;
    bit   rise, flap;
    int   vn, yn, st0;
    refr_tick = t; up = u; game_en = e; game_reset = g;
    rise = u && !m_upreg;
    st0  = m_st;
    if (g) begin
      m_y = 232; m_v = 0; m_hit = 0; m_pend = 0; m_st = 0;
    end else begin
      if (st0 == 0) begin
        if (e) m_st = 1;
      end else if (st0 == 1) begin
        if (!e) m_st = 2;
        else if (t) begin
          flap = m_pend || rise;
          vn = flap ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
          yn = m_y + vn;
          if (yn < 0) begin
            m_y = 0; m_v = 0;
          end else if (yn >= 464) begin
            m_y = 464; m_v = 0; m_hit = 1; m_st = 2;
          end else begin
            m_y = yn; m_v = vn;
          end
        end
      end
      if (t) m_pend = 0;
      else if (st0 == 1 && rise) m_pend = 1;
    end
    m_upreg = u;
    ex.y = m_y; ex.v = m_v; ex.hit = m_hit; ex.act = (m_st == 1) ? 1 : 0;
    q.push_back(ex);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk("sb_y",   int'(box_y),     ex.y);
    chk("sb_vel", int'(box_vel),   ex.v);
    chk("sb_hit", int'(bound_hit), ex.hit);
    chk("sb_act", int'(active),    ex.act);
    refr_tick  = 1'b0;
    game_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv[11];
    int fy[4];
    int y_hold;
    int budget;
    fv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10};
    fy = '{233, 235, 238, 242};

    hard_reset_n = 1'b0; refr_tick = 1'b0; game_en = 1'b0; game_reset = 1'b0; up = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y",   int'(box_y),     232);
    chk("rst_vel", int'(box_vel),   0);
    chk("rst_hit", int'(bound_hit), 0);
    chk("rst_act", int'(active),    0);
    hard_reset_n = 1'b1;

    // Ticks in HOLD are ignored
    cycle(1, 0, 0, 0);
    chk("hold_y", int'(box_y), 232);

    // Free fall
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      cycle(1, 0, 1, 0);
      chk("ff_vel", int'(box_vel), fv[i]);
      if (i < 4) chk("ff_y", int'(box_y), fy[i]);
      cycle(0, 0, 1, 0);
    end

    // Flap coalescing from vel 5
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 0);
      cycle(0, 0, 1, 0);
    end
    chk("co_vel5", int'(box_vel), 5);
    chk("co_y5",   int'(box_y),   247);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("co_flap_vel", int'(box_vel), -8);
    chk("co_flap_y",   int'(box_y),   239);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("co_next_vel", int'(box_vel), -7);
    chk("co_next_y",   int'(box_y),   232);

    // Rise coincident with tick
    cycle(1, 1, 1, 0);
    chk("edge_vel", int'(box_vel), -8);
    chk("edge_y",   int'(box_y),   224);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("edge_nopend_vel", int'(box_vel), -7);

    // Fall to the floor
    budget = 0;
    while (!bound_hit && budget < 60) begin
      cycle(1, 0, 1, 0);
      budget++;
    end
    chk("floor_hit", int'(bound_hit), 1);
    chk("floor_y",   int'(box_y),     464);
    chk("floor_vel", int'(box_vel),   0);
    chk("floor_act", int'(active),    0);
    cycle(1, 1, 1, 0);
    cycle(1, 0, 1, 0);
    chk("dead_y", int'(box_y), 464);

    // Restart with a same-cycle up rise: no flap may leak through
    cycle(0, 1, 1, 1);
    chk("rs_y",   int'(box_y),     232);
    chk("rs_hit", int'(bound_hit), 0);
    chk("rs_act", int'(active),    0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("rs_nopend_vel", int'(box_vel), 1);

    // Ceiling: flap before every tick
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(1, 0, 1, 0);
    end
    chk("ceil_y",   int'(box_y),     0);
    chk("ceil_vel", int'(box_vel),   0);
    chk("ceil_hit", int'(bound_hit), 0);
    chk("ceil_act", int'(active),    1);

    // Pipe hit: game_en falls together with a tick
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    y_hold = int'(box_y);
    cycle(1, 0, 0, 0);
    chk("pipe_frozen_y", int'(box_y), y_hold);
    chk("pipe_act",      int'(active), 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    chk("pipe_still_y", int'(box_y), y_hold);
    cycle(0, 0, 0, 1);
    chk("pipe_rs_y", int'(box_y), 232);

    // Async reset mid-ACTIVE
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    #2;
    hard_reset_n = 1'b0;
    #1;
    chk("arst_y",   int'(box_y),     232);
    chk("arst_vel", int'(box_vel),   0);
    chk("arst_hit", int'(bound_hit), 0);
    chk("arst_act", int'(active),    0);
    model_reset();
    game_en = 1'b0;
    @(negedge clk);
    hard_reset_n = 1'b1;
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("arst_resume_y", int'(box_y), 233);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/box_physics.md
Name: box_physics

Overview:
Vertical motion engine for the player box, directly downstream of the game state machine. It consumes game_en/game_reset and the raw up button, and integrates gravity and flap impulses once per frame tick to produce box_y for the renderer and collision logic. It also raises bound_hit when the box lands on the floor; bound_hit is ORed into the collision input of the game state machine.

Parameters:
Y_START, 232, box top row after reset/game_reset
Y_TOP, 0, topmost legal box row (ceiling)
Y_BOTTOM, 479, last visible screen row (floor)
BOX_H, 16, box height in rows; floor limit y_max = Y_BOTTOM - BOX_H + 1
GRAVITY, 1, velocity increment per tick (rows/tick)
FLAP_VEL, -8, signed velocity loaded on a flap
VMAX, 10, maximum downward velocity

Ports:
clk  in  1  system clock
hard_reset_n  in  1  async active-low reset
refr_tick  in  1  one-cycle pulse per video frame, from vga sync
game_en  in  1  high while the game FSM is in the playing state
game_reset  in  1  one-cycle synchronous pulse that restarts gameplay
up  in  1  raw level of the up button
box_y  out  10  current box top row, unsigned
box_vel  out  8  current velocity, two's complement (+ = down)
bound_hit  out  1  registered; box has reached the floor
active  out  1  high in ACTIVE state

Behaviour:
- Async reset (hard_reset_n=0): box_y=Y_START, box_vel=0, bound_hit=0, flap_pend=0, up_reg=0, state=HOLD.
- game_reset=1 has the same effect synchronously, except for up_reg. It takes highest priority over tick, up and game_en in that cycle.
- up_rise = up & ~up_reg, where up_reg is a registered copy of up.
- flap_pend is sticky:
  - set by up_rise in ACTIVE;
  - cleared on every refr_tick and on game_reset;
  - multiple rises between two ticks count as one flap.
- States:
  - HOLD: outputs frozen, ticks ignored; game_en=1 -> ACTIVE next cycle.
  - ACTIVE: on refr_tick, perform the motion update below. If game_en falls (pipe collision) -> DEAD.
  - DEAD: box_y and box_vel frozen, ticks and up ignored, bound_hit holds its value; game_reset -> HOLD.
- Motion update, once per refr_tick in ACTIVE:
  - flap = flap_pend | up_rise (a same-cycle rise counts).
  - v_new = FLAP_VEL if flap, else min(box_vel + GRAVITY, VMAX).
  - y_new = box_y + v_new, computed in 12-bit signed to avoid wrap.
  - Ceiling: if y_new < Y_TOP, then box_y = Y_TOP and box_vel = 0. No hit.
  - Floor: if y_new >= y_max, then box_y = y_max, box_vel = 0, bound_hit = 1 and state -> DEAD.
  - Otherwise box_y = y_new and box_vel = v_new.
- Latency: box_y, box_vel and bound_hit update on the clock edge after the cycle in which refr_tick is high (1 cycle).
- Precedence in the same cycle: game_en fall and tick together -> DEAD, and the update is not applied.
- bound_hit is cleared only by reset or game_reset.
- box_vel stays in the range [FLAP_VEL, VMAX]; the width is 8 bits signed.

Decomposition:
- Shared package flappy_pkg:
  - screen constants Y_TOP, Y_BOTTOM, BOX_H;
  - physics constants GRAVITY, FLAP_VEL, VMAX;
  - 2-bit state encoding HOLD=00, ACTIVE=01, DEAD=10.
- One natural sub-module: rise_detect (register + AND-NOT), reusable for start/up in other blocks.
- Velocity/position datapath stays inline.

Test Plan:
1. Free fall: reset, game_en=1, ticks with no up.
   -> box_vel 1,2,3,…,10,10; box_y 233,235,238,242,…; each update lands 1 cycle after its tick.
2. Flap coalescing: in free fall at box_vel=5, pulse up twice between ticks.
   -> next tick box_vel=-8 and box_y decreases by 8; the following tick box_vel=-7.
3. Flap on tick edge: up rises in the same cycle as refr_tick.
   -> that tick applies box_vel=-8, and flap_pend is 0 afterwards.
4. Floor: free fall from Y_START.
   -> box_y clamps to 464, box_vel=0, bound_hit=1 one cycle after the landing tick; state DEAD; further ticks leave box_y=464.
5. Ceiling: flap every tick from box_y=20.
   -> box_y reaches 0, box_vel=0, bound_hit stays 0, state stays ACTIVE.
6. Pipe hit and restart: drop game_en mid-flight.
   -> box_y frozen across ticks. Then pulse game_reset together with up_rise.
   -> box_y=232, box_vel=0, bound_hit=0, flap_pend=0, state HOLD. Async reset mid-ACTIVE gives the same values immediately.
